// File: rtl/seven_seg_capture.sv
// Passive monitor for a multiplexed 4-digit common-anode 7-segment bus.
// Rebuilds the displayed decimal digits and reports them as one binary value per scan frame.
module seven_seg_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg,
    input  logic [3:0]  an,
    output logic [13:0] value,
    output logic        valid,
    output logic        err,
    output logic        ovf,
    output logic        multi_err
);

    typedef enum logic {COLLECT, CONVERT} state_t;

    logic [6:0]  seg_meta_reg, seg_sync_reg;
    logic [3:0]  an_meta_reg, an_sync_reg;
    logic [1:0]  primed_reg;
    logic [10:0] last_reg;
    logic [7:0]  cnt_reg;

    state_t      state_reg;
    logic [3:0]  digit_reg [4];
    logic [3:0]  snap_reg [4];
    logic [3:0]  seen_reg, bad_reg, bad_snap_reg;
    logic [13:0] acc_reg;
    logic [1:0]  step_reg;

    logic [10:0] cur;
    logic        sample_evt;
    logic [6:0]  samp_seg;
    logic [3:0]  samp_an, an_low, hit;
    logic        one_low, many_low;
    logic [3:0]  dec_digit;
    logic        dec_bad;
    logic        go;
    logic [13:0] acc_next;

    assign cur = {an_sync_reg, seg_sync_reg};

    // The counter stays cleared until the sync pipeline holds real pin data,
    // so the all-zero reset image is never taken as a sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_meta_reg <= '0;
            seg_sync_reg <= '0;
            an_meta_reg  <= '0;
            an_sync_reg  <= '0;
            primed_reg   <= '0;
            last_reg     <= '0;
            cnt_reg      <= '0;
        end else begin
            seg_meta_reg <= seg;
            seg_sync_reg <= seg_meta_reg;
            an_meta_reg  <= an;
            an_sync_reg  <= an_meta_reg;
            primed_reg   <= {primed_reg[0], 1'b1};
            last_reg     <= cur;
            if (!primed_reg[1] || cur != last_reg)
                cnt_reg <= '0;
            else if (cnt_reg < 8'(STABLE_CYCLES))
                cnt_reg <= cnt_reg + 8'd1;
        end
    end

    assign sample_evt = (cnt_reg == 8'(STABLE_CYCLES - 1));
    assign samp_an    = last_reg[10:7];
    assign samp_seg   = last_reg[6:0];
    assign an_low     = ~samp_an;
    assign one_low    = (an_low != 4'd0) && ((an_low & (an_low - 4'd1)) == 4'd0);
    assign many_low   = (an_low & (an_low - 4'd1)) != 4'd0;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hit
            assign hit[gi] = sample_evt && one_low && an_low[gi];
        end
    endgenerate

    always_comb begin
        dec_digit = 4'd0;
        dec_bad   = 1'b0;
        case (samp_seg)
            7'h40: dec_digit = 4'd0;
            7'h79: dec_digit = 4'd1;
            7'h24: dec_digit = 4'd2;
            7'h30: dec_digit = 4'd3;
            7'h19: dec_digit = 4'd4;
            7'h12: dec_digit = 4'd5;
            7'h02: dec_digit = 4'd6;
            7'h78: dec_digit = 4'd7;
            7'h00: dec_digit = 4'd8;
            7'h10: dec_digit = 4'd9;
            default: dec_bad = 1'b1;
        endcase
    end

    assign go       = (state_reg == COLLECT) && (seen_reg == 4'hF);
    assign acc_next = acc_reg * 14'd10 + {10'd0, snap_reg[2'd3 - step_reg]};

    // Capture keeps running during CONVERT; only the snapshot feeds the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= COLLECT;
            seen_reg     <= '0;
            bad_reg      <= '0;
            bad_snap_reg <= '0;
            acc_reg      <= '0;
            step_reg     <= '0;
            value        <= '0;
            valid        <= 1'b0;
            err          <= 1'b0;
            ovf          <= 1'b0;
            multi_err    <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                digit_reg[i] <= '0;
                snap_reg[i]  <= '0;
            end
        end else begin
            valid <= 1'b0;
            if (sample_evt && many_low)
                multi_err <= 1'b1;
            for (int i = 0; i < 4; i++) begin
                if (hit[i]) begin
                    digit_reg[i] <= dec_digit;
                    bad_reg[i]   <= dec_bad;
                end
            end
            seen_reg <= (go ? 4'd0 : seen_reg) | hit;

            case (state_reg)
                COLLECT: begin
                    if (go) begin
                        state_reg    <= CONVERT;
                        bad_snap_reg <= bad_reg;
                        acc_reg      <= '0;
                        step_reg     <= '0;
                        for (int i = 0; i < 4; i++)
                            snap_reg[i] <= digit_reg[i];
                    end
                end
                CONVERT: begin
                    acc_reg  <= acc_next;
                    step_reg <= step_reg + 2'd1;
                    if (step_reg == 2'd3) begin
                        value     <= acc_next;
                        err       <= |bad_snap_reg;
                        ovf       <= (acc_next > 14'd4095);
                        valid     <= 1'b1;
                        state_reg <= COLLECT;
                    end
                end
                default: state_reg <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Scoreboard bench for seven_seg_capture: scans are driven on the pins, expected
// frames are queued, and a monitor checks every valid pulse against the queue.
module tb_seven_seg_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [6:0]  seg = 7'h7F;
    logic [3:0]  an  = 4'hF;
    logic [13:0] value;
    logic        valid, err, ovf, multi_err;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [13:0] value;
        logic        err;
        logic        ovf;
    } exp_t;
    exp_t exp_q[$];

    seven_seg_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .seg(seg), .an(an),
        .value(value), .valid(valid), .err(err), .ovf(ovf), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, required %0d", name, act, req);
        end else begin
            $display("[TB] ok   %s: %0d", name, act);
        end
    endtask

    // Monitor: every valid pulse must match the oldest queued frame.
    always @(negedge clk) begin
        if (!rst && valid) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_valid: got value=%0d, required no pulse", value);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("frame_value", int'(value), int'(e.value));
                check("frame_err", int'(err), int'(e.err));
                check("frame_ovf", int'(ovf), int'(e.ovf));
            end
        end
    end

    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n);
        @(negedge clk);
        an  = a;
        seg = s;
        repeat (n - 1) @(negedge clk);
    endtask

    // Ones digit first; optional 2-cycle glitch to 8 in the middle of the ones digit.
    task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                        input logic [6:0] s0, input bit glitch);
        if (glitch) begin
            hold(4'b1110, s0, 5);
            hold(4'b1110, 7'h00, 2);
            hold(4'b1110, s0, 10);
        end else begin
            hold(4'b1110, s0, 10);
        end
        hold(4'b1101, s1, 10);
        hold(4'b1011, s2, 10);
        hold(4'b0111, s3, 10);
    endtask

    task automatic frame(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1,
                         input logic [6:0] s0, input bit glitch,
                         input int v, input bit e, input bit o, input string name);
        exp_q.push_back('{value: 14'(v), err: e, ovf: o});
        scan(s3, s2, s1, s0, glitch);
        hold(4'hF, 7'h7F, 25);
        check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_value", int'(value), 0);
        check("rst_valid", int'(valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_ovf", int'(ovf), 0);
        check("rst_multi_err", int'(multi_err), 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        frame(7'h79, 7'h24, 7'h30, 7'h19, 1'b0, 1234, 1'b0, 1'b0, "f1234");
        frame(7'h79, 7'h24, 7'h30, 7'h19, 1'b0, 1234, 1'b0, 1'b0, "f1234_again");
        frame(7'h10, 7'h10, 7'h10, 7'h10, 1'b0, 9999, 1'b0, 1'b1, "f9999");
        frame(7'h40, 7'h40, 7'h19, 7'h24, 1'b0, 42,   1'b0, 1'b0, "f0042");
        frame(7'h12, 7'h7F, 7'h12, 7'h12, 1'b0, 5055, 1'b1, 1'b1, "f5055_blank");
        frame(7'h79, 7'h24, 7'h30, 7'h19, 1'b1, 1234, 1'b0, 1'b0, "f1234_glitch");
        check("multi_err_before", int'(multi_err), 0);

        // Two anodes low: discarded sample, sticky flag, no frame.
        hold(4'b1100, 7'h40, 12);
        hold(4'hF, 7'h7F, 25);
        check("multi_err_set", int'(multi_err), 1);
        check("multi_no_frame", exp_q.size(), 0);

        frame(7'h02, 7'h78, 7'h00, 7'h10, 1'b0, 6789, 1'b0, 1'b1, "f6789");
        check("multi_err_sticky", int'(multi_err), 1);

        // Reset pulse in the middle of conversion discards the frame entirely.
        hold(4'b1110, 7'h79, 10);
        hold(4'b1101, 7'h79, 10);
        hold(4'b1011, 7'h79, 10);
        @(negedge clk);
        an  = 4'b0111;
        seg = 7'h79;
        repeat (9) @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        hold(4'hF, 7'h7F, 25);
        check("rst_conv_value", int'(value), 0);
        check("rst_conv_err", int'(err), 0);
        check("rst_conv_ovf", int'(ovf), 0);
        check("rst_conv_multi_err", int'(multi_err), 0);

        frame(7'h30, 7'h40, 7'h79, 7'h02, 1'b0, 3016, 1'b0, 1'b0, "f3016_after_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/seven_seg_capture.md
Name: seven_seg_capture

Overview:
- Passive monitor for a multiplexed 4-digit common-anode 7-segment bus (active-low segments, active-low anodes).
- Observes seg/an driven by the display driver and reconstructs the 4 displayed decimal digits.
- Converts those digits to a binary value and pulses valid once per complete scan frame.
- Lives in the debugging toolset: loopback checking of the display path, or feeding displayed values to UART/ILA.

Parameters:
STABLE_CYCLES, 4, consecutive clk cycles {an,seg} must hold unchanged before a sample is taken (legal range 2..255)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
seg  input  7  observed segments, active low, seg[6]=g … seg[0]=a; may be asynchronous to clk
an  input  4  observed digit enables, active low, an[0]=ones … an[3]=thousands; may be asynchronous to clk
value  output  14  last decoded frame, binary 0..9999
valid  output  1  one-cycle pulse when value/err/ovf update
err  output  1  last frame contained ≥1 unrecognised segment pattern (digit decoded as 0)
ovf  output  1  last frame value > 4095 (does not fit a 12-bit address)
multi_err  output  1  sticky: a stable sample had more than one anode low; cleared only by rst

Behaviour:
- One clock (clk); rst is asynchronous and active-high.
- All outputs and internal state reset to 0. Reset mid-frame or mid-conversion discards all partial data; no valid is issued for it.
- Input sync: seg and an each pass through 2 flops before any use.
- Stability counter:
  - Cleared when synced {an,seg} differs from its value on the previous cycle; otherwise increments, saturating at STABLE_CYCLES.
  - A sample event fires on the single cycle the counter reaches STABLE_CYCLES-1. One sample per stable period; glitches shorter than STABLE_CYCLES are ignored.
- Sample handling:
  - an == 4'b1111: ignored.
  - Exactly one bit low at index i: digit[i] <= decode(seg); seen[i] <= 1; bad[i] <= 1 if pattern unrecognised, else 0.
  - ≥2 bits low: sample discarded; multi_err <= 1.
- Decode table (hex, active-low): 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 10→9. Anything else (including blank 7F) → digit 0, bad set.
- FSM states:
  - COLLECT (reset state): accepts samples.
  - CONVERT: samples are still captured into digit/seen/bad; the snapshot is unaffected.
- COLLECT→CONVERT: on the first edge where seen == 4'b1111.
  - On that edge: snapshot digit[3:0] and bad into conversion registers, clear seen, acc <= 0, step <= 0.
  - A sample arriving on that same edge sets its seen bit after the clear.
- CONVERT: four edges, thousands first, acc <= acc*10 + snap[3-step].
  - acc is 14 bits; max 9999, no overflow possible.
  - On the 4th edge: value <= result; err <= |bad_snap; ovf <= (result > 4095); valid <= 1; state → COLLECT.
- valid is high for exactly 1 cycle. err/ovf/value hold until the next valid.
- Latency:
  - Edge E0 registers the 4th distinct digit; E1 enters CONVERT; valid is high in the cycle after E5 (5 edges after E0).
  - From pins: +2 sync cycles + STABLE_CYCLES.
- Frames need all four anodes seen; digit order is irrelevant. A repeated digit before completion overwrites digit[i].

Test Plan:
- Scan 1234 (an 1110/1101/1011/0111 with seg 19/30/24/79, each held 10 cycles) → valid pulse, value=1234, err=0, ovf=0; repeated scan → valid again every frame.
- Scan 9999 (seg 10 on all digits) → value=9999, ovf=1, err=0; then scan 0042 → value=42, ovf=0.
- Scan with digit 2 blank (seg 7F) and others 5 → value=5055, err=1.
- Mid-ones-digit glitch: seg changes to 00 for 2 cycles, then back (STABLE_CYCLES=4) → glitch ignored, value unchanged from the intended frame.
- an=1100 held stable → multi_err=1 and no valid; remains 1 through later good frames until rst.
- Assert rst for 1 cycle on the 2nd CONVERT edge → no valid; value/err/ovf=0; the next full scan yields a correct value.
